// File: rtl/result_capture_buffer.sv
// result_capture_buffer
// Captures one frame of 16-bit result elements from a valid/ready stream.
// Elements are packed two per 32-bit display word, high half first.
// The frame is held until the next start. The switch-selected word is
// registered and presented to the seven-segment driver.
module result_capture_buffer #(
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_last,
    input  logic [NUM_WORDS-1:0] sw,
    output logic [31:0]          hex_word,
    output logic                 frame_done,
    output logic [1:0]           err
);

    localparam int NUM_ELEMS = 2 * NUM_WORDS;
    localparam int CNT_W     = $clog2(NUM_ELEMS) + 1;
    localparam int IDX_W     = CNT_W - 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMS - 1);
    localparam logic [31:0]      BLANK    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [CNT_W-1:0]                r_count;
    logic                            r_done;
    logic [1:0]                      r_err;
    logic [31:0]                     r_hex;
    logic [NUM_WORDS-1:0][31:0]      w_words;
    logic                            w_xfer;
    logic                            w_final_idx;
    logic                            w_exit;
    logic [IDX_W-1:0]                w_word_idx;
    logic                            w_sel_valid;
    logic [31:0]                     w_sel_word;

    assign s_ready     = (r_state == FILL);
    // A start in the same cycle discards the element on the bus.
    assign w_xfer      = s_valid && s_ready && !start;
    assign w_final_idx = (r_count == LAST_IDX);
    // The frame ends on s_last or once the buffer is full. A full buffer
    // drops s_ready, so any surplus elements simply stall upstream.
    assign w_exit      = w_xfer && (s_last || w_final_idx);
    assign w_word_idx  = r_count[CNT_W-1:1];

    assign hex_word    = r_hex;
    assign frame_done  = r_done;
    assign err         = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A start from any state begins a fresh capture.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = FILL;
            FILL: begin
                if (start) begin
                    w_state_next = FILL;
                end else if (w_exit) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: if (start) w_state_next = FILL;
            default: w_state_next = IDLE;
        endcase
    end

    // Element counter, frame-done pulse and sticky short/long error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_done <= w_exit;
            if (start) begin
                r_count <= '0;
                r_err   <= 2'b00;
            end else if (w_xfer) begin
                r_count <= r_count + 1'b1;
                if (s_last && !w_final_idx) r_err[0] <= 1'b1;
                if (!s_last && w_final_idx) r_err[1] <= 1'b1;
            end
        end
    end

    // One register per display word. Even elements fill the high half and
    // odd elements fill the low half. A start clears every word.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        logic [31:0] r_word;
        logic        w_hit;

        assign w_hit      = w_xfer && (w_word_idx == IDX_W'(gi));
        assign w_words[gi] = r_word;

        // Capture this word's halves as their elements arrive.
        always_ff @(posedge clk) begin
            if (!rst_n || start) begin
                r_word <= '0;
            end else if (w_hit && !r_count[0]) begin
                r_word[31:16] <= s_data;
            end else if (w_hit && r_count[0]) begin
                r_word[15:0] <= s_data;
            end
        end
    end

    // Decode the switch bank. Only an exactly one-hot pattern selects a word.
    always_comb begin
        w_sel_word  = '0;
        w_sel_valid = (sw != '0) && ((sw & (sw - NUM_WORDS'(1))) == '0);
        for (int j = 0; j < NUM_WORDS; j++) begin
            if (sw[j]) w_sel_word = w_words[j];
        end
    end

    // Registered display word. It is blank unless a frame is held and one word is selected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hex <= BLANK;
        end else if (r_state == HOLD && w_sel_valid) begin
            r_hex <= w_sel_word;
        end else begin
            r_hex <= BLANK;
        end
    end

endmodule

// File: tb/tb_result_capture_buffer.sv
// Testbench for result_capture_buffer. Each cycle is checked against a frame-level
// reference model. The model keeps the list of captured elements and builds
// each display word from elements 2j and 2j+1.
module tb_result_capture_buffer;

    localparam int NW = 4;
    localparam int NE = 2 * NW;
    localparam int PH_IDLE = 0;
    localparam int PH_FILL = 1;
    localparam int PH_HOLD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_data;
    logic          s_last;
    logic [NW-1:0] sw;
    logic [31:0]   hex_word;
    logic          frame_done;
    logic [1:0]    err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    int          m_phase;
    int          m_cnt;
    logic [15:0] m_el [NE];
    logic [1:0]  m_err;
    logic        m_done;
    logic [31:0] m_hex;

    logic [15:0] frame1 [NE] = '{16'h0D0E, 16'h0F10, 16'h0102, 16'h0304,
                                 16'h000D, 16'h001C, 16'h002D, 16'h0040};

    result_capture_buffer #(.DATA_W(16), .NUM_WORDS(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .sw         (sw),
        .hex_word   (hex_word),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int j);
        return {m_el[2*j], m_el[2*j+1]};
    endfunction

    task automatic m_reset();
        m_phase = PH_IDLE;
        m_cnt   = 0;
        m_err   = 2'b00;
        m_done  = 1'b0;
        m_hex   = 32'hFFFF_FFFF;
        for (int k = 0; k < NE; k++) m_el[k] = 16'h0000;
    endtask

    // Run one clock cycle with the given inputs. The model is updated from
    // its pre-edge view, and the DUT is checked 1 ns after the edge.
    task automatic cycle(input logic st, input logic v, input logic [15:0] d,
                         input logic l, input logic [NW-1:0] s, input logic rn);
        int sel;
        @(negedge clk);
        rst_n   = rn;
        start   = st;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        sw      = s;
        #1;
        check("s_ready", {31'b0, s_ready}, {31'b0, (m_phase == PH_FILL)});
        @(posedge clk);
        sel = -1;
        if ($countones(s) == 1)
            for (int j = 0; j < NW; j++) if (s[j]) sel = j;
        m_hex  = (m_phase == PH_HOLD && sel >= 0) ? m_word(sel) : 32'hFFFF_FFFF;
        m_done = 1'b0;
        if (!rn) begin
            m_reset();
        end else if (st) begin
            m_phase = PH_FILL;
            m_cnt   = 0;
            m_err   = 2'b00;
            for (int k = 0; k < NE; k++) m_el[k] = 16'h0000;
        end else if (m_phase == PH_FILL && v) begin
            m_el[m_cnt] = d;
            m_cnt++;
            if (l || m_cnt == NE) begin
                m_phase = PH_HOLD;
                m_done  = 1'b1;
                if (l && m_cnt < NE)  m_err[0] = 1'b1;
                if (!l && m_cnt == NE) m_err[1] = 1'b1;
            end
        end
        #1;
        check("hex_word", hex_word, m_hex);
        check("frame_done", {31'b0, frame_done}, {31'b0, m_done});
        check("err", {30'b0, err}, {30'b0, m_err});
    endtask

    task automatic idle_cycles(input int n, input logic [NW-1:0] s);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0, s, 1'b1);
    endtask

    initial begin
        int r;
        logic [NW-1:0] rs;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; sw = '0;
        repeat (2) @(posedge clk);
        m_reset();
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b0);
        check("reset_hex", hex_word, 32'hFFFF_FFFF);

        // 1. Full frame, then read each word
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0000, 1'b1);
        for (int k = 0; k < NE; k++) cycle(1'b0, 1'b1, frame1[k], (k == NE-1), 4'b0000, 1'b1);
        check("full_done", {31'b0, frame_done}, 32'd1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        check("full_w0", hex_word, 32'h0D0E0F10);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0010, 1'b1);
        check("full_w1", hex_word, 32'h01020304);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0100, 1'b1);
        check("full_w2", hex_word, 32'h000D001C);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b1000, 1'b1);
        check("full_w3", hex_word, 32'h002D0040);
        // 5a. invalid select in HOLD
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0011, 1'b1);
        check("multi_sel", hex_word, 32'hFFFF_FFFF);

        // 2. Gaps, then stray valids in HOLD
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < NE; k++) begin
            cycle(1'b0, 1'b0, 16'hDEAD, 1'b0, 4'b0001, 1'b1);
            cycle(1'b0, 1'b1, frame1[k], (k == NE-1), 4'b0001, 1'b1);
        end
        check("gap_done", {31'b0, frame_done}, 32'd1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 16'hBEEF, 1'b0, 4'b1000, 1'b1);
        check("gap_w3", hex_word, 32'h002D0040);

        // 3. Short frame
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, frame1[k], (k == 2), 4'b0000, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0010, 1'b1);
        check("short_w1", hex_word, 32'h01020000);
        check("short_err", {30'b0, err}, 32'd1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0100, 1'b1);
        check("short_w2", hex_word, 32'h00000000);

        // 4. Long frame (no s_last), 5b. select during FILL
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < NE; k++) cycle(1'b0, 1'b1, frame1[k], 1'b0, 4'b0001, 1'b1);
        check("long_err", {30'b0, err}, 32'd2);
        check("long_done", {31'b0, frame_done}, 32'd1);
        idle_cycles(2, 4'b0001);
        check("long_ready", {31'b0, s_ready}, 32'd0);

        // 6a. Reset mid-capture, then a full frame
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, frame1[k], 1'b0, 4'b0001, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b0);
        check("rst_err", {30'b0, err}, 32'd0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < NE; k++) cycle(1'b0, 1'b1, frame1[k], (k == NE-1), 4'b0001, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        check("rst_w0", hex_word, 32'h0D0E0F10);

        // 6b. Start coincident with the 5th transfer
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, frame1[k], 1'b0, 4'b0001, 1'b1);
        cycle(1'b1, 1'b1, frame1[4], 1'b0, 4'b0001, 1'b1);
        cycle(1'b0, 1'b1, 16'hAAAA, 1'b1, 4'b0001, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, 1'b1);
        check("restart_w0", hex_word, 32'hAAAA0000);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 4'b0100, 1'b1);
        check("restart_w2", hex_word, 32'h00000000);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) rs = NW'(1) << $urandom_range(0, NW-1);
            else if (r == 7) rs = '0;
            else rs = NW'($urandom);
            cycle(($urandom_range(0, 29) == 0), 1'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) == 0), rs, ($urandom_range(0, 299) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
